// File: rtl/pipe_mux_pkg.sv
// Shared limits and helpers for the pipelined channel multiplexer.
package pipe_mux_pkg;

    localparam int STAGES_MAX    = 3;
    localparam int NUM_IN_MIN    = 2;
    localparam int NUM_IN_MAX    = 16;
    localparam int WIDTH_DEFAULT = 18;

    // Select width for n channels: ceil(log2(n)), never less than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// One pipeline stage: a W-bit register with asynchronous reset and clock enable.
module pipe_reg
    import pipe_mux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture the stage input on enabled edges; reset clears it at any time.
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the chain shifts by one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_mux.sv
// Pipelined N-to-1 channel multiplexer; valid and raw select travel with the data.
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEFAULT,
    parameter  int NUM_IN = 4,
    parameter  int STAGES = 1,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CE,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    // Stage word layout, MSB first: {valid, sel, data}.
    localparam int SW = WIDTH + SEL_W + 1;

    // With no registers in the path, the error flag samples every rising edge.
    localparam logic ERR_ANY_EDGE = (STAGES == 0);

    generate
        if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
            $fatal(1, "pipe_mux: NUM_IN=%0d outside %0d..%0d", NUM_IN, NUM_IN_MIN, NUM_IN_MAX);
        end
        if (STAGES < 0 || STAGES > STAGES_MAX) begin : g_bad_stages
            $fatal(1, "pipe_mux: STAGES=%0d outside 0..%0d", STAGES, STAGES_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_oor;
    logic [SW-1:0]    w_stage [STAGES+1];
    logic             r_sel_err;

    // Select the addressed channel; selects past the last channel give all-zero data.
    always_comb begin
        // NOTE: defaults are assigned before the loop so every path drives
        // both outputs and no latch is inferred.
        w_sel_data = '0;
        w_sel_oor  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = in_bus[k*WIDTH +: WIDTH];
                w_sel_oor  = 1'b0;
            end
        end
    end

    // Stage 0 is the unregistered select result; data is loaded even when invalid.
    assign w_stage[0] = {in_valid, sel, w_sel_data};

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            pipe_reg #(
                .W (SW)
            ) u_reg (
                .i_clk (CLK),
                .i_rst (RST),
                .i_ce  (CE),
                .i_d   (w_stage[g]),
                .o_q   (w_stage[g+1])
            );
        end
    endgenerate

    assign {out_valid, out_sel, out} = w_stage[STAGES];

    // Sticky flag for a valid out-of-range select; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sel_err <= 1'b0;
        end else if ((CE || ERR_ANY_EDGE) && in_valid && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_pipe_mux.sv
// Self-checking bench for pipe_mux: four configurations share one stimulus bus.
module tb_pipe_mux;

    localparam int W = 18;

    typedef struct packed {
        logic         v;
        logic [1:0]   s;
        logic [W-1:0] d;
    } smp_t;

    typedef struct {
        logic [1:0]   sel;
        logic         v;
        logic         ce;
        logic [W-1:0] exp_d;
        logic         exp_v;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CE = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [W-1:0] ch [4];
    logic [4*W-1:0] in_bus4;
    logic [3*W-1:0] in_bus3;

    assign in_bus4 = {ch[3], ch[2], ch[1], ch[0]};
    assign in_bus3 = {ch[2], ch[1], ch[0]};

    logic [W-1:0] s2_out, s3_out, n3_out, s0_out;
    logic         s2_v, s3_v, n3_v, s0_v;
    logic [1:0]   s2_sel, s3_sel, n3_sel, s0_sel;
    logic         s2_err, s3_err, n3_err, s0_err;

    pipe_mux #(.WIDTH(W), .NUM_IN(4), .STAGES(2)) u_s2 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus4), .sel(sel), .in_valid(in_valid),
        .out(s2_out), .out_valid(s2_v), .out_sel(s2_sel), .sel_err(s2_err));

    pipe_mux #(.WIDTH(W), .NUM_IN(4), .STAGES(3)) u_s3 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus4), .sel(sel), .in_valid(in_valid),
        .out(s3_out), .out_valid(s3_v), .out_sel(s3_sel), .sel_err(s3_err));

    pipe_mux #(.WIDTH(W), .NUM_IN(3), .STAGES(1)) u_n3 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus3), .sel(sel), .in_valid(in_valid),
        .out(n3_out), .out_valid(n3_v), .out_sel(n3_sel), .sel_err(n3_err));

    pipe_mux #(.WIDTH(W), .NUM_IN(3), .STAGES(0)) u_s0 (
        .CLK(CLK), .RST(RST), .CE(CE), .in_bus(in_bus3), .sel(sel), .in_valid(in_valid),
        .out(s0_out), .out_valid(s0_v), .out_sel(s0_sel), .sel_err(s0_err));

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a history of what was captured on each enabled edge.
    // A STAGES=N output is the capture from N enabled edges ago.
    smp_t q4[$];
    smp_t q3[$];
    logic err_n3;
    logic err_s0;

    function automatic smp_t capture(input int n);
        smp_t c;
        c.v = in_valid;
        c.s = sel;
        c.d = (int'(sel) < n) ? ch[sel] : '0;
        return c;
    endfunction

    function automatic smp_t pick(input smp_t q[$], input int n);
        return q[q.size() - n];
    endfunction

    task automatic model_reset();
        smp_t z;
        z = '0;
        q4.delete();
        q3.delete();
        repeat (3) begin
            q4.push_back(z);
            q3.push_back(z);
        end
        err_n3 = 1'b0;
        err_s0 = 1'b0;
    endtask

    // One clock: record what the edge captures, then settle 2 units past it.
    task automatic tick();
        smp_t c4, c3;
        logic en, ev_n3, ev_s0;
        c4    = capture(4);
        c3    = capture(3);
        en    = CE;
        ev_s0 = in_valid && (sel == 2'd3);
        ev_n3 = CE && ev_s0;
        @(posedge CLK);
        if (en) begin
            q4.push_back(c4);
            q3.push_back(c3);
            if (q4.size() > 4) void'(q4.pop_front());
            if (q3.size() > 4) void'(q3.pop_front());
        end
        if (ev_n3) err_n3 = 1'b1;
        if (ev_s0) err_s0 = 1'b1;
        #2;
    endtask

    // Called 2 units after a rising edge; releases reset on the falling edge.
    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #3;
        RST = 1'b0;
    endtask

    task automatic check_rand(input int i);
        smp_t e;
        e = pick(q4, 2);
        check($sformatf("rand[%0d] s2 out", i), 32'(s2_out), 32'(e.d));
        check($sformatf("rand[%0d] s2 valid", i), 32'(s2_v), 32'(e.v));
        check($sformatf("rand[%0d] s2 sel", i), 32'(s2_sel), 32'(e.s));
        e = pick(q4, 3);
        check($sformatf("rand[%0d] s3 out", i), 32'(s3_out), 32'(e.d));
        check($sformatf("rand[%0d] s3 valid", i), 32'(s3_v), 32'(e.v));
        check($sformatf("rand[%0d] s3 sel", i), 32'(s3_sel), 32'(e.s));
        e = pick(q3, 1);
        check($sformatf("rand[%0d] n3 out", i), 32'(n3_out), 32'(e.d));
        check($sformatf("rand[%0d] n3 valid", i), 32'(n3_v), 32'(e.v));
        check($sformatf("rand[%0d] n3 sel", i), 32'(n3_sel), 32'(e.s));
        check($sformatf("rand[%0d] n3 err", i), 32'(n3_err), 32'(err_n3));
        e = capture(3);
        check($sformatf("rand[%0d] s0 out", i), 32'(s0_out), 32'(e.d));
        check($sformatf("rand[%0d] s0 valid", i), 32'(s0_v), 32'(e.v));
        check($sformatf("rand[%0d] s0 err", i), 32'(s0_err), 32'(err_s0));
        check($sformatf("rand[%0d] s2 err", i), 32'(s2_err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[7];

        ch[0] = 18'h00A5A;
        ch[1] = 18'h15555;
        ch[2] = 18'h2ABCD;
        ch[3] = 18'h3FFFF;

        // Reset holds everything at zero even with CE and in_valid active.
        CE = 1'b1;
        in_valid = 1'b1;
        sel = 2'd3;
        #32;
        check("reset s2 out", 32'(s2_out), 32'd0);
        check("reset s2 valid", 32'(s2_v), 32'd0);
        check("reset s2 sel", 32'(s2_sel), 32'd0);
        check("reset s3 valid", 32'(s3_v), 32'd0);
        check("reset n3 sel", 32'(n3_sel), 32'd0);
        check("reset n3 err", 32'(n3_err), 32'd0);
        check("reset s0 err", 32'(s0_err), 32'd0);
        in_valid = 1'b0;
        sel = 2'd0;
        @(posedge CLK);
        #2;
        do_reset();

        // Latency: one valid pulse on channel 2 appears on the 2nd edge for one cycle.
        CE = 1'b1;
        sel = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("latency edge1 valid", 32'(s2_v), 32'd0);
        tick();
        check("latency edge2 out", 32'(s2_out), 32'h2ABCD);
        check("latency edge2 valid", 32'(s2_v), 32'd1);
        check("latency edge2 sel", 32'(s2_sel), 32'd2);
        tick();
        check("latency edge3 valid", 32'(s2_v), 32'd0);
        check("latency edge3 data ungated", 32'(s2_out), 32'h2ABCD);

        // Stall: stream 1,2,3 on channel 1 with CE low for three cycles.
        do_reset();
        CE = 1'b1;
        sel = 2'd1;
        in_valid = 1'b1;
        ch[1] = 18'd1;
        tick();
        ch[1] = 18'd2;
        tick();
        check("stall first out", 32'(s2_out), 32'd1);
        check("stall first valid", 32'(s2_v), 32'd1);
        CE = 1'b0;
        ch[1] = 18'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall hold%0d out", i), 32'(s2_out), 32'd1);
            check($sformatf("stall hold%0d valid", i), 32'(s2_v), 32'd1);
        end
        CE = 1'b1;
        tick();
        check("stall second out", 32'(s2_out), 32'd2);
        check("stall second valid", 32'(s2_v), 32'd1);
        in_valid = 1'b0;
        tick();
        check("stall third out", 32'(s2_out), 32'd3);
        check("stall third valid", 32'(s2_v), 32'd1);
        tick();
        check("stall drained valid", 32'(s2_v), 32'd0);
        ch[1] = 18'h15555;

        // Out-of-range select on a 3-channel instance.
        do_reset();
        CE = 1'b1;
        sel = 2'd3;
        in_valid = 1'b0;
        tick();
        check("oor invalid no err", 32'(n3_err), 32'd0);
        in_valid = 1'b1;
        tick();
        check("oor out zero", 32'(n3_out), 32'd0);
        check("oor out_sel raw", 32'(n3_sel), 32'd3);
        check("oor valid", 32'(n3_v), 32'd1);
        check("oor err set", 32'(n3_err), 32'd1);
        check("oor 4ch no err", 32'(s2_err), 32'd0);
        check("oor 4ch ch3 out", 32'(u_s2.w_sel_data), 32'h3FFFF);
        in_valid = 1'b0;
        sel = 2'd0;
        repeat (10) tick();
        check("oor err sticky", 32'(n3_err), 32'd1);

        // Async reset mid-cycle with two samples in flight.
        do_reset();
        CE = 1'b1;
        in_valid = 1'b1;
        sel = 2'd3;
        tick();
        sel = 2'd1;
        ch[1] = 18'h00011;
        tick();
        ch[1] = 18'h00022;
        tick();
        check("areset pre err", 32'(n3_err), 32'd1);
        check("areset pre out", 32'(s2_out), 32'h00011);
        #2;
        RST = 1'b1;
        #1;
        check("areset out", 32'(s2_out), 32'd0);
        check("areset valid", 32'(s2_v), 32'd0);
        check("areset sel", 32'(s2_sel), 32'd0);
        check("areset err", 32'(n3_err), 32'd0);
        in_valid = 1'b0;
        model_reset();
        #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("areset flushed%0d valid", i), 32'(s2_v), 32'd0);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("areset restart edge1 valid", 32'(s2_v), 32'd0);
        tick();
        check("areset restart edge2 valid", 32'(s2_v), 32'd1);
        check("areset restart edge2 out", 32'(s2_out), 32'h00022);
        ch[1] = 18'h15555;

        // Zero stages: combinational path, CE has no effect.
        tbl[0] = '{sel: 2'd0, v: 1'b1, ce: 1'b1, exp_d: 18'h00A5A, exp_v: 1'b1};
        tbl[1] = '{sel: 2'd1, v: 1'b1, ce: 1'b1, exp_d: 18'h15555, exp_v: 1'b1};
        tbl[2] = '{sel: 2'd0, v: 1'b0, ce: 1'b1, exp_d: 18'h00A5A, exp_v: 1'b0};
        tbl[3] = '{sel: 2'd1, v: 1'b1, ce: 1'b0, exp_d: 18'h15555, exp_v: 1'b1};
        tbl[4] = '{sel: 2'd2, v: 1'b1, ce: 1'b0, exp_d: 18'h2ABCD, exp_v: 1'b1};
        tbl[5] = '{sel: 2'd3, v: 1'b1, ce: 1'b1, exp_d: 18'h00000, exp_v: 1'b1};
        tbl[6] = '{sel: 2'd3, v: 1'b0, ce: 1'b0, exp_d: 18'h00000, exp_v: 1'b0};
        tick();
        for (int i = 0; i < 7; i++) begin
            sel = tbl[i].sel;
            in_valid = tbl[i].v;
            CE = tbl[i].ce;
            #1;
            check($sformatf("zero-stage row%0d out", i), 32'(s0_out), 32'(tbl[i].exp_d));
            check($sformatf("zero-stage row%0d valid", i), 32'(s0_v), 32'(tbl[i].exp_v));
            check($sformatf("zero-stage row%0d sel", i), 32'(s0_sel), 32'(tbl[i].sel));
        end
        sel = 2'd0;
        in_valid = 1'b0;
        tick();

        // Zero stages: error flag sets on any edge, even with CE low.
        do_reset();
        CE = 1'b0;
        sel = 2'd3;
        in_valid = 1'b1;
        tick();
        check("zero-stage err any edge", 32'(s0_err), 32'd1);
        check("one-stage err needs CE", 32'(n3_err), 32'd0);
        in_valid = 1'b0;
        sel = 2'd0;

        // Select switching every cycle through a 3-stage pipe.
        do_reset();
        CE = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                sel = 2'(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 2 && i < 6) begin
                check($sformatf("switch ch%0d out", i - 2), 32'(s3_out), 32'(ch[i-2]));
                check($sformatf("switch ch%0d sel", i - 2), 32'(s3_sel), 32'(i - 2));
                check($sformatf("switch ch%0d valid", i - 2), 32'(s3_v), 32'd1);
            end else if (i == 6) begin
                check("switch drained valid", 32'(s3_v), 32'd0);
            end
        end

        // Random traffic against the capture-history model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) ch[k] = 18'($urandom);
            sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            CE = ($urandom_range(0, 3) != 0);
            tick();
            check_rand(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
